// File: rtl/stuffed_flag_tx_pkg.sv
// Shared definitions for the stuffed-flag serial transmitter.
//   state_e   : transmitter FSM states
//   flag_bit  : value of bit <idx> of a flag (0, flag_len ones, 0)
package stuffed_flag_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPEN,
        ST_DATA,
        ST_STUFF,
        ST_CLOSE
    } state_e;

    // A flag is flag_len+2 bits long: a leading 0, flag_len ones, a trailing 0.
    function automatic logic flag_bit(input int idx, input int flag_len);
        return !(idx == 0 || idx == flag_len + 1);
    endfunction

endpackage

// File: rtl/stuffed_flag_tx_bit_stuffer.sv
// Tracks the run of consecutive payload ones on the serial line and requests
// a stuff 0 once the run reaches FLAG_LEN-1.
//   clk, reset_n : clock, async active-low reset
//   bit_in       : bit currently on the line
//   advance      : bit_in is a payload bit (any other bit breaks the run)
//   stuff_req    : this payload 1 completes a STUFF_RUN run; next bit must be 0
//   run_cnt      : ones counted so far, including earlier cycles only
module stuffed_flag_tx_bit_stuffer #(
    parameter int FLAG_LEN = 4,
    localparam int CW      = $clog2(FLAG_LEN + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          bit_in,
    input  logic          advance,
    output logic          stuff_req,
    output logic [CW-1:0] run_cnt
);

    localparam int STUFF_RUN = FLAG_LEN - 1;

    logic [CW-1:0] run_cnt_q, run_cnt_d;

    // Stuff, flag and idle bits all break the run, so only payload bits count.
    always_comb begin
        run_cnt_d = '0;
        if (advance && bit_in) run_cnt_d = run_cnt_q + CW'(1);
    end

    assign stuff_req = advance && bit_in && (run_cnt_q == CW'(STUFF_RUN - 1));
    assign run_cnt   = run_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) run_cnt_q <= '0;
        else          run_cnt_q <= run_cnt_d;
    end

endmodule

// File: rtl/stuffed_flag_tx.sv
// Serial frame transmitter: open flag, bit-stuffed payload words (MSB first),
// close flag. A stuff 0 follows every FLAG_LEN-1 payload ones so a run of
// FLAG_LEN ones only ever appears inside a flag.
//   clk, reset_n  : clock, async active-low reset
//   din/din_valid/din_last/din_ready : word input handshake
//   aout          : registered serial line, idles at 0
//   busy          : high from first open-flag bit through last close-flag bit
//   underrun_err  : one-cycle pulse when no word is ready mid-frame
module stuffed_flag_tx
    import stuffed_flag_tx_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int FLAG_LEN = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    input  logic              din_last,
    output logic              din_ready,
    output logic              aout,
    output logic              busy,
    output logic              underrun_err
);

    localparam int STUFF_RUN = FLAG_LEN - 1;
    localparam int IW        = $clog2(FLAG_LEN + 2);
    localparam int BW        = $clog2(DATA_W + 1);
    localparam int CW        = $clog2(FLAG_LEN + 1);

    // state_q names the kind of bit currently on aout.
    state_e            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;          // flag bit index
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;  // payload bit index within word
    logic [DATA_W-1:0] shreg_q, shreg_d;      // remaining payload bits, MSB next
    logic              last_flag_q, last_flag_d;
    logic              word_done_q, word_done_d;  // stuff bit follows the word's final bit
    logic              aout_q, aout_d;
    logic              underrun_q, underrun_d;

    logic              stuff_req;
    logic [CW-1:0]     run_cnt;
    logic              last_bit;
    logic              complete;

    stuffed_flag_tx_bit_stuffer #(.FLAG_LEN(FLAG_LEN)) u_stuffer (
        .clk       (clk),
        .reset_n   (reset_n),
        .bit_in    (aout_q),
        .advance   (state_q == ST_DATA),
        .stuff_req (stuff_req),
        .run_cnt   (run_cnt)
    );

    assign last_bit = (bit_cnt_q == BW'(DATA_W - 1));
    // A word finishes on its final bit unless a stuff is due, in which case
    // it finishes in that stuff cycle instead.
    assign complete = (state_q == ST_DATA && !stuff_req && last_bit) ||
                      (state_q == ST_STUFF && word_done_q);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        last_flag_d = last_flag_q;
        word_done_d = word_done_q;
        aout_d      = 1'b0;
        underrun_d  = 1'b0;
        din_ready   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                din_ready = 1'b1;
                if (din_valid) begin
                    state_d     = ST_OPEN;
                    idx_d       = '0;
                    aout_d      = flag_bit(0, FLAG_LEN);
                    shreg_d     = din;
                    last_flag_d = din_last;
                end
            end
            ST_OPEN: begin
                if (idx_q == IW'(FLAG_LEN + 1)) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                    aout_d    = shreg_q[DATA_W-1];
                    shreg_d   = shreg_q << 1;
                end else begin
                    idx_d  = idx_q + IW'(1);
                    aout_d = flag_bit(int'(idx_q) + 1, FLAG_LEN);
                end
            end
            ST_DATA: begin
                word_done_d = last_bit;
                if (stuff_req) begin
                    state_d = ST_STUFF;
                end else if (!last_bit) begin
                    bit_cnt_d = bit_cnt_q + BW'(1);
                    aout_d    = shreg_q[DATA_W-1];
                    shreg_d   = shreg_q << 1;
                end
            end
            ST_STUFF: begin
                if (!word_done_q) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = bit_cnt_q + BW'(1);
                    aout_d    = shreg_q[DATA_W-1];
                    shreg_d   = shreg_q << 1;
                end
            end
            ST_CLOSE: begin
                if (idx_q == IW'(FLAG_LEN + 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    idx_d  = idx_q + IW'(1);
                    aout_d = flag_bit(int'(idx_q) + 1, FLAG_LEN);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (complete) begin
            if (last_flag_q) begin
                state_d = ST_CLOSE;
                idx_d   = '0;
                aout_d  = flag_bit(0, FLAG_LEN);
            end else begin
                din_ready = 1'b1;
                if (din_valid) begin
                    // Next word's MSB follows immediately, no gap.
                    state_d     = ST_DATA;
                    bit_cnt_d   = '0;
                    aout_d      = din[DATA_W-1];
                    shreg_d     = din << 1;
                    last_flag_d = din_last;
                end else begin
                    underrun_d = 1'b1;
                    state_d    = ST_CLOSE;
                    idx_d      = '0;
                    aout_d     = flag_bit(0, FLAG_LEN);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            last_flag_q <= 1'b0;
            word_done_q <= 1'b0;
            aout_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            last_flag_q <= last_flag_d;
            word_done_q <= word_done_d;
            aout_q      <= aout_d;
            underrun_q  <= underrun_d;
        end
    end

    assign aout         = aout_q;
    assign busy         = (state_q != ST_IDLE);
    assign underrun_err = underrun_q;

    // Stuffing bounds every payload run at STUFF_RUN ones.
    assert property (@(posedge clk) run_cnt <= CW'(STUFF_RUN));

endmodule
